// File: rtl/pipelined_prefix_addsub.sv
// pipelined_prefix_addsub
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake on both sides.
// Stage 0 conditions the operands. Stages 1..LEVELS each register one prefix level.
// The final stage registers the sum and the status flags.
// Latency is LEVELS+2 cycles and throughput is one beat per cycle.
// The whole pipeline stalls together when the output is held.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   in_a, in_b            operands, WIDTH bits
//   in_cin                carry-in, used in add mode only
//   in_sub                1 = A-B, 0 = A+B+cin
//   out_valid / out_ready result beat handshake
//   out_sum               result, WIDTH bits
//   out_cout              carry out (add) / not-borrow (sub)
//   out_ovf               signed two's-complement overflow
//   out_zero              out_sum == 0
//
// Optional build macro: PREFIX_ADDSUB_SAT_EN.
// When it is defined, an overflowing result saturates to the signed limit selected by
// the sign of A. out_ovf still reports the overflow, and out_zero follows the saturated value.

module pipelined_prefix_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    // Elaboration-time parameter sanity
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_prefix_addsub: WIDTH must be a power of two in 4..64");
    end
    if (LEVELS != $clog2(WIDTH)) begin : g_bad_levels
        $error("pipelined_prefix_addsub: LEVELS is derived and must not be overridden");
    end

    // Global stall: every register advances only when the output slot is free or draining
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage 0 operand conditioning; carry-in is folded into the bit-0 generate
    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] g_c;
    logic             c0_c;

    assign b_c  = in_sub ? ~in_b : in_b;
    assign c0_c = in_sub | in_cin;
    assign p_c  = in_a ^ b_c;
    assign g_c  = (in_a & b_c) | {{(WIDTH-1){1'b0}}, p_c[0] & c0_c};

    // Pipeline registers; index k holds the state after prefix level k (0 = conditioned operands)
    logic [LEVELS:0]              vld_q;
    logic [LEVELS:0]              c0_q;
    logic [LEVELS:0][WIDTH-1:0]   porig_q;
    logic [LEVELS:0][WIDTH-1:0]   g_q;
    logic [LEVELS-1:0][WIDTH-1:0] pg_q;
`ifdef PREFIX_ADDSUB_SAT_EN
    logic [LEVELS:0]              amsb_q;
`endif

    logic [LEVELS:0][WIDTH-1:0]   g_nxt;
    logic [LEVELS-1:0][WIDTH-1:0] pg_nxt;

    assign g_nxt[0]  = g_c;
    assign pg_nxt[0] = p_c;

    // Kogge-Stone levels. Bits below the span pass through.
    // The group propagate is not needed after the last level.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int unsigned D = 2 ** (k - 1);
        assign g_nxt[k] = g_q[k-1] | (pg_q[k-1] & (g_q[k-1] << D));
        if (k < LEVELS) begin : g_prop
            localparam logic [WIDTH-1:0] LO_MASK = WIDTH'((65'd1 << D) - 65'd1);
            assign pg_nxt[k] = pg_q[k-1] & ((pg_q[k-1] << D) | LO_MASK);
        end
    end

    // Sum stage: every group generate already includes the carry-in
    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

`ifdef PREFIX_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        carry_c  = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
        cout_nxt = g_q[LEVELS][WIDTH-1];
        ovf_nxt  = carry_c[WIDTH-1] ^ cout_nxt;
        sum_nxt  = porig_q[LEVELS] ^ carry_c;
`ifdef PREFIX_ADDSUB_SAT_EN
        if (ovf_nxt) begin
            sum_nxt = amsb_q[LEVELS] ? SAT_NEG : SAT_POS;
        end
`endif
    end

    // All pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            c0_q      <= '0;
            porig_q   <= '0;
            g_q       <= '0;
            pg_q      <= '0;
`ifdef PREFIX_ADDSUB_SAT_EN
            amsb_q    <= '0;
`endif
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            vld_q     <= {vld_q[LEVELS-1:0], in_valid};
            c0_q      <= {c0_q[LEVELS-1:0], c0_c};
            porig_q   <= {porig_q[LEVELS-1:0], p_c};
            g_q       <= g_nxt;
            pg_q      <= pg_nxt;
`ifdef PREFIX_ADDSUB_SAT_EN
            amsb_q    <= {amsb_q[LEVELS-1:0], in_a[WIDTH-1]};
`endif
            out_valid <= vld_q[LEVELS];
            // Result fields only load with a real beat so bubbles leave them untouched
            if (vld_q[LEVELS]) begin
                out_sum  <= sum_nxt;
                out_cout <= cout_nxt;
                out_ovf  <= ovf_nxt;
                out_zero <= ~|sum_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// Testbench for pipelined_prefix_addsub.
// Runs directed 16-bit vectors, a stalled random stream, and a reset with beats in flight.
// Also runs an exhaustive 4-bit sweep and a random 64-bit sweep.

module tb_pipelined_prefix_addsub;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

`ifdef PREFIX_ADDSUB_SAT_EN
    localparam logic [15:0] S0 = 16'h7FFF;
    localparam logic [15:0] S3 = 16'h8000;
    localparam logic [15:0] S7 = 16'h8000;
    localparam logic        Z7 = 1'b0;
`else
    localparam logic [15:0] S0 = 16'h8000;
    localparam logic [15:0] S3 = 16'h7FFF;
    localparam logic [15:0] S7 = 16'h0000;
    localparam logic        Z7 = 1'b1;
`endif

    // Hand-computed directed vectors: a, b, cin, sub -> sum, cout, ovf, zero
    vec_t vecs [8] = '{
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, S0,       1'b0, 1'b1, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, S3,       1'b1, 1'b1, 1'b0},
        '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0},
        '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, S7,       1'b1, 1'b1, Z7}
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 16-bit instance
    logic        i16_valid, i16_ready, i16_cin, i16_sub, o16_valid, o16_ready;
    logic        o16_cout, o16_ovf, o16_zero;
    logic [15:0] i16_a, i16_b, o16_sum;

    pipelined_prefix_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i16_valid), .in_ready(i16_ready),
        .in_a(i16_a), .in_b(i16_b), .in_cin(i16_cin), .in_sub(i16_sub),
        .out_valid(o16_valid), .out_ready(o16_ready),
        .out_sum(o16_sum), .out_cout(o16_cout), .out_ovf(o16_ovf), .out_zero(o16_zero)
    );

    // 4-bit instance
    logic       i4_valid, i4_ready, i4_cin, i4_sub, o4_valid, o4_ready;
    logic       o4_cout, o4_ovf, o4_zero;
    logic [3:0] i4_a, i4_b, o4_sum;

    pipelined_prefix_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i4_valid), .in_ready(i4_ready),
        .in_a(i4_a), .in_b(i4_b), .in_cin(i4_cin), .in_sub(i4_sub),
        .out_valid(o4_valid), .out_ready(o4_ready),
        .out_sum(o4_sum), .out_cout(o4_cout), .out_ovf(o4_ovf), .out_zero(o4_zero)
    );

    // 64-bit instance
    logic        i64_valid, i64_ready, i64_cin, i64_sub, o64_valid, o64_ready;
    logic        o64_cout, o64_ovf, o64_zero;
    logic [63:0] i64_a, i64_b, o64_sum;

    pipelined_prefix_addsub #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i64_valid), .in_ready(i64_ready),
        .in_a(i64_a), .in_b(i64_b), .in_cin(i64_cin), .in_sub(i64_sub),
        .out_valid(o64_valid), .out_ready(o64_ready),
        .out_sum(o64_sum), .out_cout(o64_cout), .out_ovf(o64_ovf), .out_zero(o64_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference at width w: wide add of A + B' + c0, sign rule for overflow
    function automatic res_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] bb;
        logic        c0;
        res_t        r;
        mask   = (65'd1 << w) - 65'd1;
        bb     = sub ? (~b & mask[63:0]) : b;
        c0     = sub | cin;
        full   = {1'b0, a} + {1'b0, bb} + 65'(c0);
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
`ifdef PREFIX_ADDSUB_SAT_EN
        if (r.ovf) r.sum = a[w-1] ? (64'd1 << (w - 1)) : (mask[63:0] >> 1);
`endif
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    // One isolated 16-bit beat; returns the result and the cycles from acceptance to out_valid
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         output res_t r, output int lat);
        i16_a = a; i16_b = b; i16_cin = cin; i16_sub = sub;
        i16_valid = 1'b1;
        o16_ready = 1'b1;
        step();
        i16_valid = 1'b0;
        lat = 1;
        while (!o16_valid && lat < 20) begin
            step();
            lat++;
        end
        r.sum  = 64'(o16_sum);
        r.cout = o16_cout;
        r.ovf  = o16_ovf;
        r.zero = o16_zero;
        step();
    endtask

    initial begin
        res_t r;
        int   lat;

        i16_valid = 0; i16_a = 0; i16_b = 0; i16_cin = 0; i16_sub = 0; o16_ready = 0;
        i4_valid  = 0; i4_a  = 0; i4_b  = 0; i4_cin  = 0; i4_sub  = 0; o4_ready  = 1;
        i64_valid = 0; i64_a = 0; i64_b = 0; i64_cin = 0; i64_sub = 0; o64_ready = 1;

        // Reset state
        repeat (3) step();
        check("rst_valid", 64'(o16_valid), 64'd0);
        check("rst_sum",   64'(o16_sum),   64'd0);
        check("rst_flags", 64'({o16_cout, o16_ovf, o16_zero}), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_ready", 64'(i16_ready), 64'd1);

        // Directed 16-bit vectors with latency
        for (int i = 0; i < 8; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r, lat);
            check($sformatf("v%0d_lat", i),  64'(lat),    64'd6);
            check($sformatf("v%0d_sum", i),  r.sum,       64'(vecs[i].s));
            check($sformatf("v%0d_cout", i), 64'(r.cout), 64'(vecs[i].co));
            check($sformatf("v%0d_ovf", i),  64'(r.ovf),  64'(vecs[i].ov));
            check($sformatf("v%0d_zero", i), 64'(r.zero), 64'(vecs[i].z));
        end

        // Random stream with pseudo-random backpressure
        begin : stream
            res_t        q[$];
            res_t        e;
            logic [15:0] held;
            logic        stalled, pend;
            int          sent, got, cyc;
            stalled = 0; pend = 0; sent = 0; got = 0; cyc = 0; held = '0;
            while (got < 20 && cyc < 400) begin
                o16_ready = 1'($urandom_range(0, 1));
                if (!pend && sent < 20 && $urandom_range(0, 3) != 0) begin
                    i16_a   = 16'($urandom);
                    i16_b   = 16'($urandom);
                    i16_cin = 1'($urandom);
                    i16_sub = 1'($urandom);
                    pend    = 1'b1;
                end
                i16_valid = pend;
                #1;
                if (stalled) begin
                    check("stall_valid", 64'(o16_valid), 64'd1);
                    check("stall_sum",   64'(o16_sum),   64'(held));
                end
                stalled = o16_valid && !o16_ready;
                held    = o16_sum;
                if (o16_valid && o16_ready) begin
                    if (q.size() == 0) begin
                        check("stream_spurious", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("stream_%0d", got),
                              64'({o16_zero, o16_ovf, o16_cout, o16_sum}),
                              64'({e.zero, e.ovf, e.cout, e.sum[15:0]}));
                    end
                    got++;
                end
                if (i16_valid && i16_ready) begin
                    q.push_back(model(32'd16, 64'(i16_a), 64'(i16_b), i16_cin, i16_sub));
                    sent++;
                    pend = 1'b0;
                end
                step();
                cyc++;
            end
            i16_valid = 1'b0;
            o16_ready = 1'b1;
            check("stream_got",   64'(got),      64'd20);
            check("stream_drain", 64'(q.size()), 64'd0);
            repeat (8) step();
        end

        // Reset with one beat at the output and two more in flight
        begin : midreset
            int seen;
            o16_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                i16_a = 16'hFFFF; i16_b = 16'(i + 2); i16_cin = 0; i16_sub = 0;
                i16_valid = 1'b1;
                step();
            end
            i16_valid = 1'b0;
            repeat (3) step();
            check("pre_rst_valid", 64'(o16_valid), 64'd1);
            check("pre_rst_sum",   64'(o16_sum),   64'h0001);
            rst_n = 1'b0;
            #1;
            check("mid_rst_valid", 64'(o16_valid), 64'd0);
            check("mid_rst_sum",   64'(o16_sum),   64'd0);
            check("mid_rst_flags", 64'({o16_cout, o16_ovf, o16_zero}), 64'd0);
            step();
            rst_n = 1'b1;
            seen = 0;
            repeat (10) begin
                step();
                if (o16_valid) seen++;
            end
            check("rst_stale", 64'(seen), 64'd0);
            run16(16'h1234, 16'h4321, 1'b1, 1'b0, r, lat);
            check("post_rst_lat", 64'(lat),   64'd6);
            check("post_rst_sum", r.sum,      64'h5556);
        end

        // Exhaustive 4-bit: add cin=0, add cin=1, sub (cin set, must be ignored)
        begin : w4
            res_t q4[$];
            res_t e;
            int   lat4;
            lat4 = -1;
            for (int cyc = 0; cyc < 768 + 20; cyc++) begin
                if (cyc < 768) begin
                    i4_a   = 4'(cyc % 16);
                    i4_b   = 4'((cyc / 16) % 16);
                    i4_sub = (cyc / 256) == 2;
                    i4_cin = (cyc / 256) != 0;
                    i4_valid = 1'b1;
                    q4.push_back(model(32'd4, 64'(i4_a), 64'(i4_b), i4_cin, i4_sub));
                end else begin
                    i4_valid = 1'b0;
                end
                step();
                if (o4_valid) begin
                    if (lat4 < 0) lat4 = cyc + 1;
                    if (q4.size() == 0) begin
                        check("w4_spurious", 64'd1, 64'd0);
                    end else begin
                        e = q4.pop_front();
                        check("w4_result", 64'({o4_zero, o4_ovf, o4_cout, o4_sum}),
                              64'({e.zero, e.ovf, e.cout, e.sum[3:0]}));
                    end
                end
            end
            check("w4_latency", 64'(lat4),       64'd4);
            check("w4_drain",   64'(q4.size()),  64'd0);
        end

        // Random 64-bit add and sub
        begin : w64
            res_t q64[$];
            res_t e;
            int   lat64;
            lat64 = -1;
            for (int cyc = 0; cyc < 10000 + 20; cyc++) begin
                if (cyc < 10000) begin
                    i64_a   = {$urandom, $urandom};
                    i64_b   = {$urandom, $urandom};
                    i64_cin = 1'($urandom);
                    i64_sub = 1'($urandom);
                    i64_valid = 1'b1;
                    q64.push_back(model(32'd64, i64_a, i64_b, i64_cin, i64_sub));
                end else begin
                    i64_valid = 1'b0;
                end
                step();
                if (o64_valid) begin
                    if (lat64 < 0) lat64 = cyc + 1;
                    if (q64.size() == 0) begin
                        check("w64_spurious", 64'd1, 64'd0);
                    end else begin
                        e = q64.pop_front();
                        check("w64_sum",   o64_sum, e.sum);
                        check("w64_flags", 64'({o64_zero, o64_ovf, o64_cout}),
                              64'({e.zero, e.ovf, e.cout}));
                    end
                end
            end
            check("w64_latency", 64'(lat64),      64'd8);
            check("w64_drain",   64'(q64.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
